// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Default geometry, port-count limits and the hardwired-zero register index.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH_POW = 6;
    localparam int DEF_MEM_DEPTH_POW  = 5;
    localparam int DEF_DATA_W         = 1 << DEF_DATA_WIDTH_POW;
    localparam int DEF_IDX_W          = DEF_MEM_DEPTH_POW;

    localparam int MAX_RD_PORTS = 8;
    localparam int MAX_WR_PORTS = 4;

    typedef logic [DEF_IDX_W-1:0]  reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_wr_arbiter.sv
// Reduces all write ports to one (hit, data) pair for a single target index.
// The highest-numbered matching port wins; the zero register never hits.
module reg_file_wr_arbiter
    import reg_file_pkg::*;
#(
    parameter int NUM_WR = 1,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic [IDX_W-1:0]         target_i,
    input  logic [NUM_WR-1:0]        en_i,
    input  logic [NUM_WR*IDX_W-1:0]  idx_i,
    input  logic [NUM_WR*DATA_W-1:0] data_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    always_comb begin
        // NOTE: defaults are assigned first so every path drives both outputs; without them a latch is inferred.
        hit_o  = 1'b0;
        data_o = '0;
        if (target_i != IDX_W'(ZERO_REG)) begin
            // Ascending scan: a later (higher) port overwrites an earlier match.
            for (int w = 0; w < NUM_WR; w++) begin
                if (en_i[w] && (idx_i[w*IDX_W +: IDX_W] == target_i)) begin
                    hit_o  = 1'b1;
                    data_o = data_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: x0 hardwired to zero, synchronous clear,
// optional same-cycle write bypass and optional registered read outputs.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = DEF_DATA_WIDTH_POW,
    parameter int REG_MEM_DEPTH_POW  = DEF_MEM_DEPTH_POW,
    parameter int NUM_RD             = 2,
    parameter int NUM_WR             = 1,
    parameter int READ_LATENCY       = 0,
    parameter int BYPASS             = 1
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [NUM_RD*REG_MEM_DEPTH_POW-1:0]  rs_in,
    input  logic [NUM_WR*REG_MEM_DEPTH_POW-1:0]  rd_in,
    input  logic [NUM_WR*(1<<REG_DATA_WIDTH_POW)-1:0] data_write,
    input  logic [NUM_WR-1:0]                    write_en,
    output logic [NUM_RD*(1<<REG_DATA_WIDTH_POW)-1:0] reg_data_out
);

    localparam int W  = 1 << REG_DATA_WIDTH_POW;
    localparam int D  = 1 << REG_MEM_DEPTH_POW;
    localparam int IW = REG_MEM_DEPTH_POW;

    // Reset outranks writes, for both the array and the bypass path.
    logic [NUM_WR-1:0] wr_en_eff;
    assign wr_en_eff = write_en & {NUM_WR{~rst_in}};

    logic [W-1:0] mem_q  [1:D-1];
    logic [W-1:0] mem_d  [1:D-1];
    logic [D-1:1] wr_hit;
    logic [W-1:0] wr_data [1:D-1];
    logic [W-1:0] rd_arr [D];

    for (genvar i = 1; i < D; i++) begin : g_wr
        reg_file_wr_arbiter #(
            .NUM_WR (NUM_WR),
            .IDX_W  (IW),
            .DATA_W (W)
        ) u_arb (
            .target_i (IW'(i)),
            .en_i     (wr_en_eff),
            .idx_i    (rd_in),
            .data_i   (data_write),
            .hit_o    (wr_hit[i]),
            .data_o   (wr_data[i])
        );
    end

    always_comb begin
        for (int i = 1; i < D; i++) begin
            mem_d[i] = wr_hit[i] ? wr_data[i] : mem_q[i];
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: the array itself is reset here because clear-on-reset is architectural, not just an init convenience.
        if (rst_in) begin
            for (int i = 1; i < D; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int i = 1; i < D; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_arr[0] = '0;
    for (genvar i = 1; i < D; i++) begin : g_rd_arr
        assign rd_arr[i] = mem_q[i];
    end

    logic [NUM_RD*W-1:0] rd_val;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [IW-1:0] idx;
        assign idx = rs_in[r*IW +: IW];

        if (BYPASS != 0) begin : g_byp
            logic         byp_hit;
            logic [W-1:0] byp_data;

            reg_file_wr_arbiter #(
                .NUM_WR (NUM_WR),
                .IDX_W  (IW),
                .DATA_W (W)
            ) u_byp (
                .target_i (idx),
                .en_i     (wr_en_eff),
                .idx_i    (rd_in),
                .data_i   (data_write),
                .hit_o    (byp_hit),
                .data_o   (byp_data)
            );

            // The arbiter already masks x0, so a hit never targets register 0.
            assign rd_val[r*W +: W] = byp_hit ? byp_data : rd_arr[idx];
        end else begin : g_nobyp
            assign rd_val[r*W +: W] = rd_arr[idx];
        end
    end

    if (READ_LATENCY != 0) begin : g_out_reg
        logic [NUM_RD*W-1:0] out_q;
        logic [NUM_RD*W-1:0] out_d;

        assign out_d = rd_val;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign reg_data_out = out_q;
    end else begin : g_out_comb
        assign reg_data_out = rd_val;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: four instances covering every READ_LATENCY/BYPASS
// combination, driven by shared directed and random stimulus.
module tb_reg_file_mp;

    localparam int W  = 64;
    localparam int IW = 5;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk_in;
    logic              rst_in;
    logic [NR*IW-1:0]  rs_in;
    logic [NW*IW-1:0]  rd_in;
    logic [NW*W-1:0]   data_write;
    logic [NW-1:0]     write_en;
    logic [NR*W-1:0]   out00, out01, out10, out11;

    int total = 0;
    int bad   = 0;

    reg_file_mp #(.NUM_RD(NR), .NUM_WR(NW), .READ_LATENCY(0), .BYPASS(0)) dut00 (
        .clk_in(clk_in), .rst_in(rst_in), .rs_in(rs_in), .rd_in(rd_in),
        .data_write(data_write), .write_en(write_en), .reg_data_out(out00));
    reg_file_mp #(.NUM_RD(NR), .NUM_WR(NW), .READ_LATENCY(0), .BYPASS(1)) dut01 (
        .clk_in(clk_in), .rst_in(rst_in), .rs_in(rs_in), .rd_in(rd_in),
        .data_write(data_write), .write_en(write_en), .reg_data_out(out01));
    reg_file_mp #(.NUM_RD(NR), .NUM_WR(NW), .READ_LATENCY(1), .BYPASS(0)) dut10 (
        .clk_in(clk_in), .rst_in(rst_in), .rs_in(rs_in), .rd_in(rd_in),
        .data_write(data_write), .write_en(write_en), .reg_data_out(out10));
    reg_file_mp #(.NUM_RD(NR), .NUM_WR(NW), .READ_LATENCY(1), .BYPASS(1)) dut11 (
        .clk_in(clk_in), .rst_in(rst_in), .rs_in(rs_in), .rd_in(rd_in),
        .data_write(data_write), .write_en(write_en), .reg_data_out(out11));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: architectural register contents plus expected registered outputs.
    logic [W-1:0] model_mem [D];
    logic [W-1:0] exp10_q [NR];
    logic [W-1:0] exp11_q [NR];
    bit           model_valid = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] port_out(input logic [NR*W-1:0] bus, input int r);
        return bus[r*W +: W];
    endfunction

    // Value a read port must see this cycle, from the architectural rules.
    function automatic logic [W-1:0] model_read(input int r, input bit byp);
        int idx;
        idx = int'(rs_in[r*IW +: IW]);
        if (idx == 0) return '0;
        if (byp && !rst_in) begin
            for (int w = NW - 1; w >= 0; w--) begin
                if (write_en[w] && int'(rd_in[w*IW +: IW]) == idx) return data_write[w*W +: W];
            end
        end
        return model_mem[idx];
    endfunction

    always @(posedge clk_in) begin
        for (int r = 0; r < NR; r++) begin
            exp10_q[r] = rst_in ? '0 : model_read(r, 1'b0);
            exp11_q[r] = rst_in ? '0 : model_read(r, 1'b1);
        end
        if (rst_in) begin
            for (int k = 0; k < D; k++) model_mem[k] = '0;
            model_valid = 1'b1;
        end else begin
            for (int k = 1; k < D; k++) begin
                for (int w = NW - 1; w >= 0; w--) begin
                    if (write_en[w] && int'(rd_in[w*IW +: IW]) == k) begin
                        model_mem[k] = data_write[w*W +: W];
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (model_valid) begin
            for (int r = 0; r < NR; r++) begin
                check($sformatf("cmp00_p%0d", r), port_out(out00, r), model_read(r, 1'b0));
                check($sformatf("cmp01_p%0d", r), port_out(out01, r), model_read(r, 1'b1));
                check($sformatf("cmp10_p%0d", r), port_out(out10, r), exp10_q[r]);
                check($sformatf("cmp11_p%0d", r), port_out(out11, r), exp11_q[r]);
            end
        end
    end

    task automatic drive(input bit rst,
                         input bit e0, input int a0, input logic [W-1:0] d0,
                         input bit e1, input int a1, input logic [W-1:0] d1,
                         input int s0, input int s1);
        logic [IW-1:0] ia0, ia1, is0, is1;
        ia0 = a0[IW-1:0];
        ia1 = a1[IW-1:0];
        is0 = s0[IW-1:0];
        is1 = s1[IW-1:0];
        rst_in     = rst;
        write_en   = {e1, e0};
        rd_in      = {ia1, ia0};
        data_write = {d1, d0};
        rs_in      = {is1, is0};
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int pick_idx();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, D - 1));
    endfunction

    localparam logic [W-1:0] ALL_ONES = '1;

    initial begin
        drive(1'b1, 0, 0, '0, 0, 0, '0, 0, 0);
        step();

        // Write x5, then a reset cycle whose own write must be lost.
        drive(1'b0, 1, 5, 64'hDEAD, 0, 0, '0, 5, 5);
        @(negedge clk_in);
        check("lit_byp_dead", port_out(out01, 0), 64'hDEAD);
        check("lit_nobyp_pre", port_out(out00, 0), 64'h0);
        step();
        drive(1'b1, 1, 5, 64'h77, 0, 0, '0, 5, 5);
        @(negedge clk_in);
        check("lit_stored_dead", port_out(out00, 0), 64'hDEAD);
        check("lit_rst_nobyp", port_out(out01, 0), 64'hDEAD);
        step();
        drive(1'b0, 0, 0, '0, 0, 0, '0, 5, 5);
        @(negedge clk_in);
        for (int r = 0; r < NR; r++) begin
            check("lit_rst_00", port_out(out00, r), 64'h0);
            check("lit_rst_01", port_out(out01, r), 64'h0);
            check("lit_rst_10", port_out(out10, r), 64'h0);
            check("lit_rst_11", port_out(out11, r), 64'h0);
        end
        step();

        // Read-after-write on x7.
        drive(1'b0, 1, 7, 64'h1234, 0, 0, '0, 7, 7);
        @(negedge clk_in);
        check("lit_raw_old_p0", port_out(out00, 0), 64'h0);
        check("lit_raw_old_p1", port_out(out00, 1), 64'h0);
        check("lit_raw_byp", port_out(out01, 0), 64'h1234);
        step();
        drive(1'b0, 0, 0, '0, 0, 0, '0, 7, 7);
        @(negedge clk_in);
        check("lit_raw_new_p0", port_out(out00, 0), 64'h1234);
        check("lit_raw_new_p1", port_out(out00, 1), 64'h1234);
        check("lit_rl1_rdfirst", port_out(out10, 0), 64'h0);
        check("lit_rl1_wrfirst", port_out(out11, 0), 64'h1234);
        step();

        drive(1'b0, 1, 3, 64'hCAFE, 0, 0, '0, 3, 7);
        @(negedge clk_in);
        check("lit_bypass_cafe", port_out(out01, 0), 64'hCAFE);
        check("lit_rl1_late", port_out(out10, 0), 64'h1234);
        step();

        // Write collision on x9, then a disabled high port on x4.
        drive(1'b0, 1, 9, 64'hAAAA, 1, 9, 64'hBBBB, 9, 9);
        @(negedge clk_in);
        check("lit_coll_byp", port_out(out01, 0), 64'hBBBB);
        step();
        drive(1'b0, 1, 4, 64'h11, 0, 4, 64'h99, 9, 4);
        @(negedge clk_in);
        check("lit_coll_x9", port_out(out00, 0), 64'hBBBB);
        check("lit_dis_byp_x4", port_out(out01, 1), 64'h11);
        step();

        // Writes to x0 from both ports.
        drive(1'b0, 1, 0, ALL_ONES, 1, 0, ALL_ONES, 0, 4);
        @(negedge clk_in);
        check("lit_x0_byp", port_out(out01, 0), 64'h0);
        check("lit_x4_kept", port_out(out00, 1), 64'h11);
        step();
        drive(1'b0, 0, 0, '0, 0, 0, '0, 0, 9);
        @(negedge clk_in);
        check("lit_x0_rl1", port_out(out11, 0), 64'h0);
        check("lit_x0_next", port_out(out00, 0), 64'h0);
        check("lit_x9_kept", port_out(out00, 1), 64'hBBBB);
        step();

        // Registered read of x2, write-first versus read-first.
        drive(1'b0, 1, 2, 64'h55, 0, 0, '0, 2, 3);
        @(negedge clk_in);
        check("lit_byp_55", port_out(out01, 0), 64'h55);
        step();
        drive(1'b0, 0, 0, '0, 0, 0, '0, 2, 3);
        @(negedge clk_in);
        check("lit_rl1_byp_55", port_out(out11, 0), 64'h55);
        check("lit_rl1_nobyp_old", port_out(out10, 0), 64'h0);
        check("lit_x3_cafe", port_out(out00, 1), 64'hCAFE);
        step();
        @(negedge clk_in);
        check("lit_rl1_nobyp_55", port_out(out10, 0), 64'h55);
        step();

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 1) == 1, pick_idx(), {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, pick_idx(), {$urandom, $urandom},
                  pick_idx(), pick_idx());
            step();
        end

        drive(1'b0, 0, 0, '0, 0, 0, '0, 0, 0);
        @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
